// File: rtl/truth_table_sequencer_if.sv
// ----------------------------------------------------------------------------
// truth_table_sequencer_if
// Groups the sweep-control and result signals between the truth-table
// sequencer and its environment (block under control plus supervisor).
//   start          : run request, sampled only while idle
//   expected       : required f per vector (bit k -> vector k)
//   f              : output of the combinational block under control
//   vec            : input vector driven to the block (MSB = a)
//   busy / done    : sweep running / one-cycle end-of-sweep pulse
//   pass           : last sweep matched expected exactly
//   captured       : sampled f per vector
//   mismatch_count : number of vectors whose f differed from expected
// Modports: master = sequencer side, slave = environment side.
// ----------------------------------------------------------------------------
interface truth_table_sequencer_if #(
    parameter int unsigned N_IN = 4
);
    localparam int unsigned NVec = 2 ** N_IN;

    logic              start;
    logic [NVec-1:0]   expected;
    logic              f;
    logic [N_IN-1:0]   vec;
    logic              busy;
    logic              done;
    logic              pass;
    logic [NVec-1:0]   captured;
    logic [N_IN:0]     mismatch_count;

    modport master (
        input  start, expected, f,
        output vec, busy, done, pass, captured, mismatch_count
    );

    modport slave (
        output start, expected, f,
        input  vec, busy, done, pass, captured, mismatch_count
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// ----------------------------------------------------------------------------
// truth_table_sequencer
// Exhaustively sweeps the 2^N_IN input vectors of a combinational block in
// ascending order, holding each for DWELL cycles and sampling f in the last
// cycle of the hold. The captured truth table is compared against a mask
// latched at start.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears all state and results
//   bus : truth_table_sequencer_if.master (start/expected/f in, results out)
// Parameters:
//   N_IN  : number of function inputs
//   DWELL : cycles each vector is held (>= 1)
// ----------------------------------------------------------------------------
module truth_table_sequencer #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned DWELL = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    truth_table_sequencer_if.master       bus
);
    localparam int unsigned NVec = 2 ** N_IN;
    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned MW   = N_IN + 1;

    localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);
    localparam logic [N_IN-1:0] VecLast = {N_IN{1'b1}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NVec-1:0]   exp_q, exp_d;
    logic [NVec-1:0]   capt_q, capt_d;
    logic [MW-1:0]     mism_q, mism_d;
    logic              pass_q, pass_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q  <= '0;
            cnt_q  <= '0;
            exp_q  <= '0;
            capt_q <= '0;
            mism_q <= '0;
            pass_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            exp_q  <= exp_d;
            capt_q <= capt_d;
            mism_q <= mism_d;
            pass_q <= pass_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        capt_d  = capt_q;
        mism_d  = mism_q;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    exp_d   = bus.expected;
                    capt_d  = '0;
                    mism_d  = '0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    cnt_d          = '0;
                    capt_d[vec_q]  = bus.f;
                    if (bus.f != exp_q[vec_q]) begin
                        mism_d = mism_q + MW'(1);
                    end
                    if (vec_q == VecLast) begin
                        // pass must already include the last vector so it is
                        // valid in the same cycle as the done pulse.
                        state_d = StDone;
                        pass_d  = (mism_d == '0);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end
            end
            StDone: begin
                pass_d  = (mism_q == '0);
                vec_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy           = (state_q == StRun);
        bus.done           = (state_q == StDone);
        bus.vec            = vec_q;
        bus.pass           = pass_q;
        bus.captured       = capt_q;
        bus.mismatch_count = mism_q;
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// ----------------------------------------------------------------------------
// tb_truth_table_sequencer
// Drives two sequencers (DWELL=20 and DWELL=1) against a behavioural model of
// f = a&b | c&d (or stuck-at values). Sweep results are queued at start and
// compared when done pulses.
// ----------------------------------------------------------------------------
module tb_truth_table_sequencer;
    localparam int unsigned Dw = 20;
    localparam int SweepLen   = 16 * Dw;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    truth_table_sequencer_if #(.N_IN(4)) if20 ();
    truth_table_sequencer_if #(.N_IN(4)) if1 ();

    truth_table_sequencer #(.N_IN(4), .DWELL(Dw)) u_dut20 (
        .clk (clk),
        .rst (rst),
        .bus (if20)
    );

    truth_table_sequencer #(.N_IN(4), .DWELL(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    function automatic logic ref_f(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

    // 0: correct function, 1: stuck at 0, 2: stuck at 1
    logic [1:0] fmode = 2'd0;
    always_comb begin
        case (fmode)
            2'd0:    if20.f = ref_f(if20.vec);
            2'd1:    if20.f = 1'b0;
            default: if20.f = 1'b1;
        endcase
    end
    always_comb if1.f = ref_f(if1.vec);

    typedef struct {
        logic [1:0]  fmode;
        logic [15:0] mask;
        logic        pass;
        logic [4:0]  mism;
        logic [15:0] capt;
    } vec_t;

    typedef struct {
        logic        pass;
        logic [4:0]  mism;
        logic [15:0] capt;
        int          lat;
    } sb_t;

    vec_t tbl[5];
    sb_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"},  32'(if20.vec), 32'd0);
        chk({tag, "_busy"}, 32'(if20.busy), 32'd0);
        chk({tag, "_done"}, 32'(if20.done), 32'd0);
        chk({tag, "_pass"}, 32'(if20.pass), 32'd0);
        chk({tag, "_capt"}, 32'(if20.captured), 32'd0);
        chk({tag, "_mism"}, 32'(if20.mismatch_count), 32'd0);
    endtask

    task automatic compare_result(input string tag, input int lat, input logic p,
                                  input logic [4:0] m, input logic [15:0] c);
        sb_t r;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: got done with empty scoreboard, expected pending sweep", tag);
            return;
        end
        r = sb_q.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(r.lat));
        chk({tag, "_pass"},    32'(p),   32'(r.pass));
        chk({tag, "_mism"},    32'(m),   32'(r.mism));
        chk({tag, "_capt"},    32'(c),   32'(r.capt));
    endtask

    // Full sweep on the DWELL=20 unit. inject adds ignored start pulses at
    // vectors 3 and 9 and zeroes expected mid-run.
    task automatic run_sweep(input vec_t t, input bit inject);
        bit got;
        int lat;
        fmode          = t.fmode;
        if20.expected  = t.mask;
        if20.start     = 1'b1;
        sb_q.push_back('{pass: t.pass, mism: t.mism, capt: t.capt, lat: SweepLen});
        @(negedge clk);
        if20.start = 1'b0;
        chk("start_busy", 32'(if20.busy), 32'd1);
        chk("start_vec",  32'(if20.vec),  32'd0);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= SweepLen + 80 && !got; k++) begin
            if (inject) begin
                if (k == 3 * Dw + 4)  if20.start = 1'b1;
                if (k == 3 * Dw + 5)  if20.start = 1'b0;
                if (k == 9 * Dw + 2) begin
                    if20.start    = 1'b1;
                    if20.expected = 16'h0000;
                end
                if (k == 9 * Dw + 3)  if20.start = 1'b0;
            end
            @(negedge clk);
            if (k % Dw == 0 && k < SweepLen) chk("vec_step", 32'(if20.vec), 32'(k / Dw));
            if (k == SweepLen - 1) chk("busy_last", 32'(if20.busy), 32'd1);
            if (if20.done) begin
                got = 1'b1;
                lat = k;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: got no done, expected done at cycle %0d", SweepLen);
            void'(sb_q.pop_front());
            return;
        end
        compare_result("sweep", lat, if20.pass, if20.mismatch_count, if20.captured);
        chk("done_busy_low", 32'(if20.busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(if20.done), 32'd0);
        chk("idle_vec",       32'(if20.vec),  32'd0);
        chk("pass_held",      32'(if20.pass), 32'(t.pass));
    endtask

    initial begin
        tbl[0] = '{2'd0, 16'hF888, 1'b1, 5'd0, 16'hF888};
        tbl[1] = '{2'd1, 16'hF888, 1'b0, 5'd7, 16'h0000};
        tbl[2] = '{2'd2, 16'hF888, 1'b0, 5'd9, 16'hFFFF};
        tbl[3] = '{2'd0, 16'h0000, 1'b0, 5'd7, 16'hF888};
        tbl[4] = '{2'd0, 16'hFFFF, 1'b0, 5'd9, 16'hF888};

        if20.start    = 1'b1;
        if20.expected = 16'hFFFF;
        if1.start     = 1'b1;
        if1.expected  = 16'hFFFF;

        // Reset held with start asserted
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("reset");
        end
        rst        = 1'b0;
        if20.start = 1'b0;
        if1.start  = 1'b0;
        @(negedge clk);
        chk("reset_idle_busy", 32'(if20.busy), 32'd0);
        chk("reset_idle_dw1",  32'(if1.busy),  32'd0);

        for (int i = 0; i < 5; i++) run_sweep(tbl[i], 1'b0);

        // Start pulses and expected change during a run are ignored
        run_sweep(tbl[0], 1'b1);

        // Reset mid-run at vector 5
        fmode         = 2'd0;
        if20.expected = 16'hF888;
        if20.start    = 1'b1;
        @(negedge clk);
        if20.start = 1'b0;
        repeat (5 * Dw + 2) @(negedge clk);
        chk("midrun_vec5", 32'(if20.vec), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("midrun_rst");
        @(negedge clk);
        chk("midrun_idle", 32'(if20.busy), 32'd0);
        run_sweep(tbl[0], 1'b0);

        // DWELL=1 sweep: vec steps every cycle, 16-cycle sweep
        begin
            bit got;
            int lat;
            if1.expected = 16'hF888;
            if1.start    = 1'b1;
            sb_q.push_back('{pass: 1'b1, mism: 5'd0, capt: 16'hF888, lat: 16});
            @(negedge clk);
            if1.start = 1'b0;
            chk("dw1_busy", 32'(if1.busy), 32'd1);
            chk("dw1_vec0", 32'(if1.vec),  32'd0);
            got = 1'b0;
            lat = 0;
            for (int k = 1; k <= 40 && !got; k++) begin
                @(negedge clk);
                if (k < 16) chk("dw1_vec_step", 32'(if1.vec), 32'(k));
                if (if1.done) begin
                    got = 1'b1;
                    lat = k;
                end
            end
            if (got) begin
                compare_result("dw1", lat, if1.pass, if1.mismatch_count, if1.captured);
            end else begin
                checks++;
                errors++;
                $display("FAIL dw1_timeout: got no done, expected done at cycle 16");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
